// File: rtl/mealy_decoder_2bit_deser.sv
`default_nettype none
// ============================================================================
// Module   : mealy_decoder_2bit_deser
// Purpose  : Receive-side inverse of the 2-bit Mealy encoder (states 00/01/11).
//            Tracks the encoder state from the incoming y stream, recovers the
//            original x bits and deserialises them into W-bit words that are
//            presented on a valid/ready output register. A completed word that
//            cannot be stored sets a sticky overrun flag.
// Options  : OVR_CNT_EN - when defined, adds the saturating dropped-word
//            counter and its ovr_cnt output port.
// Revision : 1.0 - initial release
// ============================================================================
module mealy_decoder_2bit_deser #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             y_valid,
    input  logic             flush,
    output logic             x_out,
    output logic             x_valid,
    output logic [W-1:0]     word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    input  logic             clr_ovr
`ifdef OVR_CNT_EN
    ,
    output logic [CNT_W-1:0] ovr_cnt
`endif
);

    localparam int            BCW  = $clog2(W);
    localparam logic [BCW-1:0] LAST = BCW'(W - 1);

    // Reject out-of-range configurations at elaboration time.
    generate
        if ((W < 2) || (W > 32) || (CNT_W < 1)) begin : g_bad_param
            $error("mealy_decoder_2bit_deser: W must be 2..32 and CNT_W >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } dstate_t;

    dstate_t        d_state;
    logic [BCW-1:0] bit_cnt;
    logic [W-1:0]   shreg;

    dstate_t        dec_next;
    logic           dec_ok;
    logic           dec_x;
    logic           accept;
    logic           word_done;
    logic           drop;
    logic [W-1:0]   full_word;

    // Decode table: recovered bit and next encoder state for the current y_in.
    always_comb begin
        dec_ok   = 1'b0;
        dec_x    = 1'b0;
        dec_next = S00;
        case (d_state)
            S00: begin
                dec_ok   = 1'b1;
                dec_x    = ~y_in;
                dec_next = y_in ? S00 : S01;
            end
            S01: begin
                dec_ok   = 1'b1;
                dec_x    = y_in;
                dec_next = y_in ? S11 : S01;
            end
            S11: begin
                dec_ok   = 1'b1;
                dec_x    = y_in;
                dec_next = y_in ? S00 : S11;
            end
            default: begin
                // Illegal state: the bit is thrown away and the tracker resyncs to 00.
                dec_ok   = 1'b0;
                dec_x    = 1'b0;
                dec_next = S00;
            end
        endcase
    end

    // Word completion and the full word as it will look after this edge.
    always_comb begin
        accept        = y_valid & ~flush & dec_ok;
        word_done     = accept & (bit_cnt == LAST);
        drop          = word_done & word_valid & ~word_ready;
        full_word     = shreg;
        full_word[W-1] = dec_x;
    end

    // Decoder state tracker, recovered-bit register and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_state <= S00;
            bit_cnt <= '0;
            shreg   <= '0;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
        end else begin
            x_valid <= 1'b0;
            if (flush) begin
                // Flush wins over a bit sampled in the same cycle.
                d_state <= S00;
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (y_valid) begin
                d_state <= dec_next;
                if (dec_ok) begin
                    x_out          <= dec_x;
                    x_valid        <= 1'b1;
                    shreg[bit_cnt] <= dec_x;
                    bit_cnt        <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
                end
            end
        end
    end

    // Output word register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (word_done && (!word_valid || word_ready)) begin
                // A read in the same cycle frees the slot, so the new word lands.
                word_out   <= full_word;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef OVR_CNT_EN
    // Saturating dropped-word counter; a clear coinciding with a drop restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_cnt <= '0;
        end else if (drop) begin
            if (clr_ovr) begin
                ovr_cnt <= CNT_W'(1);
            end else if (!(&ovr_cnt)) begin
                ovr_cnt <= ovr_cnt + 1'b1;
            end
        end else if (clr_ovr) begin
            ovr_cnt <= '0;
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_mealy_decoder_2bit_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_decoder_2bit_deser
// Purpose  : Self-checking bench for mealy_decoder_2bit_deser. Directed
//            scenarios with fixed expectations, then randomized traffic checked
//            against an encoder + word-assembly reference model.
// Options  : OVR_CNT_EN - also checks the ovr_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_decoder_2bit_deser;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         y_in = 1'b0;
    logic         y_valid = 1'b0;
    logic         flush = 1'b0;
    logic         word_ready = 1'b0;
    logic         clr_ovr = 1'b0;
    logic         x_out;
    logic         x_valid;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         overrun;
`ifdef OVR_CNT_EN
    logic [CNT_W-1:0] ovr_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    int           enc;      // encoder state as a number: 0, 1 or 3
    bit           m_xout;
    bit           m_xv;
    int           m_bits;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_wo;
    bit           m_wv;
    bit           m_ovr;
    int           m_cnt;

    mealy_decoder_2bit_deser #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .flush      (flush),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
`ifdef OVR_CNT_EN
        ,
        .ovr_cnt    (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        enc    = 0;
        m_xout = 0;
        m_xv   = 0;
        m_bits = 0;
        m_acc  = '0;
        m_wo   = '0;
        m_wv   = 0;
        m_ovr  = 0;
        m_cnt  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        y_valid = 1'b0; flush = 1'b0; word_ready = 1'b0; clr_ovr = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Raw drive: y given directly, one clock edge, outputs sampled 1 time unit later.
    task automatic drive_y(input bit yv, input bit y, input bit fl, input bit rdy, input bit clr);
        y_valid = yv; y_in = y; flush = fl; word_ready = rdy; clr_ovr = clr;
        @(posedge clk);
        #1;
    endtask

    // Model-driven: x is encoded to y by the encoder model, and the model advances.
    task automatic drive(input bit yv, input bit x, input bit fl, input bit rdy, input bit clr);
        bit           done;
        bit           drop;
        logic [W-1:0] w;
        done = 0;
        w    = '0;
        y_valid = yv; flush = fl; word_ready = rdy; clr_ovr = clr;
        y_in = yv ? ((enc == 0) ? ~x : x) : 1'($urandom);
        @(posedge clk);
        #1;
        m_xv = 0;
        if (fl) begin
            enc = 0; m_bits = 0; m_acc = '0;
        end else if (yv) begin
            if (x) enc = (enc == 0) ? 1 : (enc == 1) ? 3 : 0;
            m_xout = x;
            m_xv   = 1;
            m_acc[m_bits] = x;
            m_bits++;
            if (m_bits == W) begin
                done = 1; w = m_acc; m_bits = 0; m_acc = '0;
            end
        end
        drop = done && m_wv && !rdy;
        if (done && !drop) begin
            m_wo = w; m_wv = 1;
        end else if (m_wv && rdy) begin
            m_wv = 0;
        end
        if (drop) begin
            m_ovr = 1;
            m_cnt = clr ? 1 : ((m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1);
        end else if (clr) begin
            m_ovr = 0; m_cnt = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        tests++;
        if ({x_out, x_valid, word_out, word_valid, overrun} !== '0) begin
            fails++;
            $display("FAIL reset_state: got x=%b xv=%b word=%h wv=%b ovr=%b, expected all 0",
                     x_out, x_valid, word_out, word_valid, overrun);
        end
`ifdef OVR_CNT_EN
        tests++;
        if (ovr_cnt !== '0) begin
            fails++;
            $display("FAIL reset_ovr_cnt: got %0d expected 0", ovr_cnt);
        end
`endif
        do_reset();
    endtask

    task automatic test_all_ones();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_y(1, 1, 0, 1, 0);
            tests++;
            if (x_valid !== 1'b1 || x_out !== 1'b0 || word_valid !== (i == 7)) begin
                fails++;
                $display("FAIL ones_bit%0d: got xv=%b x=%b wv=%b expected xv=1 x=0 wv=%b",
                         i, x_valid, x_out, word_valid, i == 7);
            end
        end
        tests++;
        if (word_out !== 8'h00) begin
            fails++;
            $display("FAIL ones_word: got %h expected 00", word_out);
        end
        drive_y(0, 0, 0, 1, 0);
        tests++;
        if (word_valid !== 1'b0 || x_valid !== 1'b0) begin
            fails++;
            $display("FAIL ones_pulse: got wv=%b xv=%b expected wv=0 xv=0", word_valid, x_valid);
        end
    endtask

    task automatic test_all_zeros();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_y(1, 0, 0, 0, 0);
            tests++;
            if (x_valid !== 1'b1 || x_out !== (i == 0)) begin
                fails++;
                $display("FAIL zeros_bit%0d: got xv=%b x=%b expected xv=1 x=%b",
                         i, x_valid, x_out, i == 0);
            end
        end
        tests++;
        if (word_valid !== 1'b1 || word_out !== 8'h01) begin
            fails++;
            $display("FAIL zeros_word: got wv=%b word=%h expected wv=1 word=01", word_valid, word_out);
        end
        // Still in state 01: y=0 must decode as x=0.
        drive_y(1, 0, 0, 0, 0);
        tests++;
        if (x_out !== 1'b0 || x_valid !== 1'b1) begin
            fails++;
            $display("FAIL zeros_state01: got x=%b xv=%b expected x=0 xv=1", x_out, x_valid);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] ys;
        logic [3:0] xs;
        ys = 4'b1110;   // y sent LSB first: 0,1,1,1
        xs = 4'b0111;   // x expected LSB first: 1,1,1,0
        do_reset();
        tests++;
        if (x_valid !== 1'b0) begin
            fails++;
            $display("FAIL seq_idle: got xv=%b expected 0", x_valid);
        end
        for (int i = 0; i < 4; i++) begin
            y_valid = 1'b1; y_in = ys[i];
            #1;
            tests++;
            if (i > 0 && (x_valid !== 1'b1 || x_out !== xs[i-1])) begin
                fails++;
                $display("FAIL seq_lag%0d: got xv=%b x=%b expected xv=1 x=%b", i, x_valid, x_out, xs[i-1]);
            end else if (i == 0 && x_valid !== 1'b0) begin
                fails++;
                $display("FAIL seq_lag0: got xv=%b expected 0 before first edge", x_valid);
            end
            @(posedge clk);
            #1;
            tests++;
            if (x_valid !== 1'b1 || x_out !== xs[i]) begin
                fails++;
                $display("FAIL seq_bit%0d: got xv=%b x=%b expected xv=1 x=%b", i, x_valid, x_out, xs[i]);
            end
        end
        drive_y(0, 0, 0, 0, 0);
        tests++;
        if (x_valid !== 1'b0) begin
            fails++;
            $display("FAIL seq_novalid: got xv=%b expected 0", x_valid);
        end
        // Back in state 00: y=1 decodes as x=0.
        drive_y(1, 1, 0, 0, 0);
        tests++;
        if (x_valid !== 1'b1 || x_out !== 1'b0) begin
            fails++;
            $display("FAIL seq_state00: got xv=%b x=%b expected xv=1 x=0", x_valid, x_out);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        a = 8'hA5; b = 8'h3C; c = 8'hFF;
        do_reset();
        for (int i = 0; i < 8; i++) drive(1, a[i], 0, 0, 0);
        tests++;
        if (word_valid !== 1'b1 || word_out !== 8'hA5 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_first: got wv=%b word=%h ovr=%b expected wv=1 word=a5 ovr=0",
                     word_valid, word_out, overrun);
        end
        for (int i = 0; i < 8; i++) drive(1, b[i], 0, 0, 0);
        tests++;
        if (word_valid !== 1'b1 || word_out !== 8'hA5 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_drop: got wv=%b word=%h ovr=%b expected wv=1 word=a5 ovr=1",
                     word_valid, word_out, overrun);
        end
`ifdef OVR_CNT_EN
        tests++;
        if (ovr_cnt !== 8'd1) begin
            fails++;
            $display("FAIL ovr_cnt_one: got %0d expected 1", ovr_cnt);
        end
`endif
        drive(0, 0, 0, 0, 1);
        tests++;
        if (overrun !== 1'b0 || word_valid !== 1'b1 || word_out !== 8'hA5) begin
            fails++;
            $display("FAIL ovr_clear: got ovr=%b wv=%b word=%h expected ovr=0 wv=1 word=a5",
                     overrun, word_valid, word_out);
        end
`ifdef OVR_CNT_EN
        tests++;
        if (ovr_cnt !== 8'd0) begin
            fails++;
            $display("FAIL ovr_cnt_clear: got %0d expected 0", ovr_cnt);
        end
`endif
        // Clear together with a fresh drop: the drop wins.
        for (int i = 0; i < 8; i++) drive(1, c[i], 0, 0, i == 7);
        tests++;
        if (overrun !== 1'b1 || word_out !== 8'hA5) begin
            fails++;
            $display("FAIL ovr_set_wins: got ovr=%b word=%h expected ovr=1 word=a5", overrun, word_out);
        end
`ifdef OVR_CNT_EN
        tests++;
        if (ovr_cnt !== 8'd1) begin
            fails++;
            $display("FAIL ovr_cnt_set_wins: got %0d expected 1", ovr_cnt);
        end
`endif
        drive(0, 0, 0, 1, 1);
        tests++;
        if (word_valid !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_read: got wv=%b ovr=%b expected wv=0 ovr=0", word_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h5A; b = 8'hC3;
        do_reset();
        for (int i = 0; i < 8; i++) drive(1, a[i], 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, b[i], 0, i == 7, 0);
        tests++;
        if (word_valid !== 1'b1 || word_out !== 8'hC3 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL b2b_load: got wv=%b word=%h ovr=%b expected wv=1 word=c3 ovr=0",
                     word_valid, word_out, overrun);
        end
        drive(0, 0, 0, 1, 0);
        tests++;
        if (word_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_read: got wv=%b expected 0", word_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive_y(1, 0, 0, 0, 0);   // -> 01
        drive_y(1, 1, 0, 0, 0);   // -> 11
        drive_y(1, 0, 0, 0, 0);   // stay 11
        drive_y(1, 1, 1, 0, 0);   // flush wins, bit ignored
        tests++;
        if (x_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_xvalid: got xv=%b expected 0", x_valid);
        end
        for (int i = 0; i < 8; i++) begin
            drive_y(1, 1, 0, 0, 0);
            tests++;
            if (x_valid !== 1'b1 || x_out !== 1'b0 || word_valid !== (i == 7)) begin
                fails++;
                $display("FAIL flush_bit%0d: got xv=%b x=%b wv=%b expected xv=1 x=0 wv=%b",
                         i, x_valid, x_out, word_valid, i == 7);
            end
        end
        tests++;
        if (word_out !== 8'h00 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL flush_word: got word=%h ovr=%b expected word=00 ovr=0", word_out, overrun);
        end
    endtask

    task automatic test_random();
        bit yv, x, fl, rdy, clr;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            yv  = ($urandom_range(3) != 0);
            x   = 1'($urandom);
            fl  = ($urandom_range(49) == 0);
            rdy = 1'($urandom);
            clr = ($urandom_range(39) == 0);
            drive(yv, x, fl, rdy, clr);
            tests++;
            if (x_valid !== m_xv || (m_xv && x_out !== m_xout)) begin
                fails++;
                $display("FAIL rnd_x c=%0d: got xv=%b x=%b expected xv=%b x=%b", c, x_valid, x_out, m_xv, m_xout);
            end
            tests++;
            if (word_valid !== m_wv || word_out !== m_wo || overrun !== m_ovr) begin
                fails++;
                $display("FAIL rnd_word c=%0d: got wv=%b word=%h ovr=%b expected wv=%b word=%h ovr=%b",
                         c, word_valid, word_out, overrun, m_wv, m_wo, m_ovr);
            end
`ifdef OVR_CNT_EN
            tests++;
            if (ovr_cnt !== CNT_W'(m_cnt)) begin
                fails++;
                $display("FAIL rnd_cnt c=%0d: got %0d expected %0d", c, ovr_cnt, m_cnt);
            end
`endif
            // Asynchronous reset between clock edges, part way through a word.
            if ((c == 1500 || c == 2500) && m_bits != 0) begin
                rst = 1'b0;
                #2;
                tests++;
                if ({x_out, x_valid, word_out, word_valid, overrun} !== '0) begin
                    fails++;
                    $display("FAIL rnd_async_rst c=%0d: got x=%b xv=%b word=%h wv=%b ovr=%b expected all 0",
                             c, x_out, x_valid, word_out, word_valid, overrun);
                end
                model_reset();
                @(negedge clk);
                rst = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_sequence();
        test_overrun();
        test_back_to_back();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
